// File: rtl/pam_pkg.sv
// rtl/pam_pkg.sv - shared types and level-mapping helpers for the PAM encoder
package pam_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Gray to binary for a 2-bit symbol; the MSB passes through unchanged
    function automatic logic [1:0] gray2bin(input logic [1:0] gray);
        return {gray[1], gray[1] ^ gray[0]};
    endfunction

    // Signed level for a symbol index; PAM-2 only looks at index[1] and
    // uses the outer two PAM-4 levels. Result is wrapped to res bits.
    function automatic int pam_level(input logic [1:0] index, input logic pam2,
                                     input int sep, input int res);
        int idx;
        int lvl;
        idx = pam2 ? (index[1] ? 3 : 0) : int'(index);
        lvl = (2 * idx - 3) * (sep / 2);
        lvl = (lvl <<< (32 - res)) >>> (32 - res);
        return lvl;
    endfunction

endpackage

// File: rtl/pam_level_map.sv
// rtl/pam_level_map.sv - combinational symbol + mode to signed level mapper
module pam_level_map
    import pam_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPARATION = 32
) (
    input  logic [1:0]                          symbol,
    input  logic                                pam2_mode,
    input  logic                                gray_en,
    output logic signed [SIGNAL_RESOLUTION-1:0] level
);

    // Two guard bits so the (2*idx-3)*sep/2 product cannot wrap before truncation
    localparam int EXT_W = SIGNAL_RESOLUTION + 2;

    logic [1:0]              index;
    logic signed [EXT_W-1:0] level_ext;

    // Decode index (Gray only matters in PAM-4, gray2bin keeps the MSB) and map to level
    always_comb begin
        index     = gray_en ? gray2bin(symbol) : symbol;
        level_ext = EXT_W'(pam_level(index, pam2_mode, SYMBOL_SEPARATION, EXT_W));
        level     = level_ext[SIGNAL_RESOLUTION-1:0];
    end

endmodule

// File: rtl/pam_encoder.sv
// rtl/pam_encoder.sv - PAM-2/PAM-4 symbol encoder with oversampled level output
module pam_encoder
    import pam_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION  = 8,
    parameter int SYMBOL_SEPARATION  = 32,
    parameter int SAMPLES_PER_SYMBOL = 4,
    parameter int CNT_W              = $clog2(SAMPLES_PER_SYMBOL + 1)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                pam2_mode,
    input  logic                                gray_en,
    input  logic [1:0]                          symbol_in,
    input  logic                                symbol_valid,
    output logic                                symbol_ready,
    output logic signed [SIGNAL_RESOLUTION-1:0] voltage_level,
    output logic                                signal_out_valid,
    input  logic                                signal_out_ready,
    output logic [15:0]                         symbols_sent
);

    if ((3 * SYMBOL_SEPARATION) / 2 > (2 ** (SIGNAL_RESOLUTION - 1)) - 1) begin : g_range_err
        $error("pam_encoder: 3*SYMBOL_SEPARATION/2 does not fit in SIGNAL_RESOLUTION bits");
    end
    if (SAMPLES_PER_SYMBOL < 1) begin : g_sps_err
        $error("pam_encoder: SAMPLES_PER_SYMBOL must be at least 1");
    end

    localparam logic [CNT_W-1:0] SPS_C = CNT_W'(SAMPLES_PER_SYMBOL);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic signed [SIGNAL_RESOLUTION-1:0] level_d;
    logic signed [SIGNAL_RESOLUTION-1:0] mapped_level;
    logic                                sent_inc;

    pam_level_map #(
        .SIGNAL_RESOLUTION (SIGNAL_RESOLUTION),
        .SYMBOL_SEPARATION (SYMBOL_SEPARATION)
    ) u_level_map (
        .symbol    (symbol_in),
        .pam2_mode (pam2_mode),
        .gray_en   (gray_en),
        .level     (mapped_level)
    );

    // State, sample counter, held level and symbol counter registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            voltage_level <= '0;
            symbols_sent  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            voltage_level <= level_d;
            if (sent_inc) begin
                symbols_sent <= symbols_sent + 16'd1;
            end
        end
    end

    // Next-state, handshake and load decisions; the last-sample retire may chain a new symbol
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        level_d          = voltage_level;
        symbol_ready     = 1'b0;
        signal_out_valid = 1'b0;
        sent_inc         = 1'b0;
        case (state_q)
            IDLE: begin
                symbol_ready = 1'b1;
                if (symbol_valid) begin
                    state_d = ACTIVE;
                    level_d = mapped_level;
                    cnt_d   = SPS_C;
                end
            end
            ACTIVE: begin
                signal_out_valid = 1'b1;
                symbol_ready     = (cnt_q == ONE_C) && signal_out_ready;
                if (signal_out_ready) begin
                    cnt_d = cnt_q - ONE_C;
                    if (cnt_q == ONE_C) begin
                        sent_inc = 1'b1;
                        if (symbol_valid) begin
                            level_d = mapped_level;
                            cnt_d   = SPS_C;
                        end else begin
                            state_d = IDLE;
                            level_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                level_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: doc/pam_encoder.md
Name: pam_encoder

Overview:
Parametrised PAM-2/PAM-4 symbol-to-level encoder for the Tx simulation path. It accepts 2-bit symbols over a valid/ready handshake and optionally Gray-decodes them. Each symbol is mapped to a signed voltage level and held for SAMPLES_PER_SYMBOL output samples, producing an oversampled level stream for the channel model. Output backpressure is supported, and mode is selectable per symbol.

Parameters:
SIGNAL_RESOLUTION, 8, width of signed output level (two's complement)
SYMBOL_SEPARATION, 32, voltage distance between adjacent PAM-4 levels; must be even
SAMPLES_PER_SYMBOL, 4, output samples emitted per accepted symbol (>=1)
CNT_W, $clog2(SAMPLES_PER_SYMBOL+1), sample counter width (derived)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
pam2_mode  in  1  1 = PAM-2 (symbol_in[1] only), 0 = PAM-4; sampled on symbol acceptance
gray_en  in  1  1 = symbol_in is Gray coded; sampled on symbol acceptance
symbol_in  in  2  input symbol
symbol_valid  in  1  symbol_in valid
symbol_ready  out  1  encoder can accept a symbol this cycle
voltage_level  out  SIGNAL_RESOLUTION  signed output sample
signal_out_valid  out  1  voltage_level valid
signal_out_ready  in  1  downstream accepts the sample
symbols_sent  out  16  count of symbols fully emitted; wraps at 2^16

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, voltage_level=0, signal_out_valid=0, sample counter=0, symbols_sent=0. Reset wins over all other inputs. Mid-symbol reset discards the remaining samples and does not increment symbols_sent.
- Elaboration check: 3*SYMBOL_SEPARATION/2 <= 2^(SIGNAL_RESOLUTION-1)-1, else $error.
- Index decode: with gray_en=1, 00->0, 01->1, 11->2, 10->3; with gray_en=0, index = binary value.
- PAM-4 level = (2*index-3)*SYMBOL_SEPARATION/2. Defaults give -48, -16, +16, +48.
- PAM-2 level: symbol_in[1]=0 -> -3*SEP/2; symbol_in[1]=1 -> +3*SEP/2. symbol_in[0] is ignored, and Gray has no effect in PAM-2.
- Level arithmetic is done in SIGNAL_RESOLUTION+2 bits and truncated; the range check above guarantees no overflow.
- Handshakes: a symbol is accepted on symbol_valid & symbol_ready; a sample is retired on signal_out_valid & signal_out_ready.
- State machine:
  - IDLE: signal_out_valid=0, symbol_ready=1. On accept -> ACTIVE, load voltage_level with the mapped level and set counter=SAMPLES_PER_SYMBOL.
  - ACTIVE: signal_out_valid=1, and voltage_level is held stable while not retired.
  - On each retire, counter decrements.
  - On the retire of the last sample (counter==1), symbols_sent increments. Then either:
    - a new symbol accepted in the same cycle: reload level and counter, stay ACTIVE; or
    - no new symbol: -> IDLE, voltage_level<=0.
- symbol_ready = (state==IDLE) | (state==ACTIVE & counter==1 & signal_out_ready). This is combinational from signal_out_ready; no other combinational paths.
- Latency: a symbol accepted at edge N appears on voltage_level after edge N. With signal_out_ready held at 1, back-to-back symbols produce a gap-free stream: exactly SAMPLES_PER_SYMBOL samples per symbol, 100% throughput.
- Backpressure: while signal_out_ready=0, voltage_level, signal_out_valid and the counter are frozen, and symbol_ready=0 in ACTIVE.
- Mode changes on pam2_mode/gray_en take effect only at the next accept; a symbol in flight is unaffected.
- SAMPLES_PER_SYMBOL=1: every accept produces exactly one sample, and symbol_ready tracks signal_out_ready in ACTIVE.

Decomposition:
- Package pam_pkg:
  - typedef enum state_t {IDLE, ACTIVE};
  - function gray2bin(2-bit);
  - function pam_level(index, pam2, sep, res) returning the signed level.
- Natural sub-module: pam_level_map, a purely combinational symbol+mode -> level mapper, reused by the future Rx slicer reference model. The counter/handshake FSM stays in pam_encoder.

Test Plan:
- Binary map: gray_en=0, pam2_mode=0, symbols 00,01,10,11, SPS=4, ready=1 -> 4x-48, 4x-16, 4x+16, 4x+48 contiguous; symbols_sent=4.
- Gray map: gray_en=1, symbols 00,01,11,10 -> -48, -16, +16, +48, each held 4 samples.
- PAM-2: pam2_mode=1, symbols 10, 01, 11 -> +48, -48, +48; symbol_in[0] has no effect.
- Backpressure: ready=0 for 3 cycles mid-symbol -> level and valid frozen, symbol_ready=0; still exactly 4 retired samples per symbol and no symbol lost.
- Reset mid-symbol: rstn=0 after 2 of 4 samples -> next cycle valid=0, level=0, symbols_sent unchanged; the next accepted symbol starts a full 4-sample burst.
- Mode switch + SPS=1 build: toggle pam2_mode every symbol with continuous valid -> one sample per cycle, each level matching the mode latched at its own acceptance; symbols_sent wraps 0xFFFF->0x0000.
